// File: rtl/btn_if.sv
// rtl/btn_if.sv - button conditioner signal bundle
// Ports (via modports):
//   slave  : input btn_raw; output btn_level, btn_press, btn_release, any_press, press_id
//   master : the mirror of slave (drives btn_raw, observes the conditioned outputs)
interface btn_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_press;
    logic [1:0]       press_id;

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, any_press, press_id
    );

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, any_press, press_id
    );
endinterface

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - synchronise, debounce and edge-detect raw push-buttons
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : btn_if.slave -- btn_raw in; btn_level, btn_press, btn_release,
//          any_press, press_id out (all registered)
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat press pulses while a button is held)
module btn_conditioner #(
    parameter int N_BTN         = 3,
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic  clk,
    input  logic  rst,
    btn_if.slave  bus
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_HI = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_WAIT_LO = 2'd3;

    if (N_BTN < 1 || N_BTN > 4 || DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_conditioner: illegal parameter value");
    end

    logic [N_BTN-1:0]         sync1_q, sync1_d;
    logic [N_BTN-1:0]         sync2_q, sync2_d;
    logic [N_BTN-1:0][1:0]    state_q, state_d;
    logic [N_BTN-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_BTN-1:0]         level_q, level_d;
    logic [N_BTN-1:0]         press_q, press_d;
    logic [N_BTN-1:0]         release_q, release_d;
    logic                     any_press_q, any_press_d;
    logic [1:0]               press_id_q, press_id_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_DELAY + REPEAT_PERIOD);
    logic [N_BTN-1:0][RW-1:0] rcnt_q, rcnt_d;
`endif

    always_comb begin
`ifdef BTN_AUTOREPEAT_EN
        logic [RW-1:0] rnext;
        rnext  = '0;
        rcnt_d = rcnt_q;
`endif
        sync1_d   = bus.btn_raw;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            case (state_q[i])
                S_IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_WAIT_HI;
                        cnt_d[i]   = CW'(1);
                    end
                end
                S_WAIT_HI: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = S_HELD;
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rcnt_d[i]  = '0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                S_HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_WAIT_LO;
                        cnt_d[i]   = CW'(1);
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else begin
                        // Once past the first repeat, the counter folds back to
                        // R_FIRST so it never needs to grow beyond one period.
                        rnext     = rcnt_q[i] + RW'(1);
                        rcnt_d[i] = rnext;
                        if (rnext == R_FIRST) begin
                            press_d[i] = 1'b1;
                        end else if (rnext == R_NEXT) begin
                            press_d[i] = 1'b1;
                            rcnt_d[i]  = R_FIRST;
                        end
                    end
`endif
                end
                default: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i]   = S_IDLE;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            endcase
        end

        for (int i = 0; i < N_BTN; i++) begin
            level_d[i] = (state_d[i] == S_HELD) || (state_d[i] == S_WAIT_LO);
        end

        any_press_d = |press_d;
        press_id_d  = 2'd0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_d[i]) begin
                press_id_d = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= {N_BTN{S_IDLE}};
            cnt_q       <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            any_press_q <= 1'b0;
            press_id_q  <= 2'd0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_q      <= '0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            any_press_q <= any_press_d;
            press_id_q  <= press_id_d;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_q      <= rcnt_d;
`endif
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.any_press   = any_press_q;
    assign bus.press_id    = press_id_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner
module tb_btn_conditioner;
    localparam int N  = 3;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btn_if #(.N_BTN(N)) bus ();

    btn_conditioner #(
        .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: raw delayed two samples, then a change is accepted
    // after DB consecutive samples that differ from the current level.
    logic [N-1:0] h1 = '0, h2 = '0, m_lvl = '0;
    logic [N-1:0] e_lvl = '0, e_pr = '0, e_rl = '0;
    logic         e_any = 1'b0;
    logic [1:0]   e_id = 2'd0;
    int           run[N];
    int           rep[N];

    typedef struct {
        logic [N-1:0] raw;
        int           cycles;
        logic [N-1:0] lvl_end;
        int           presses;
        int           releases;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic s;
        e_pr = '0;
        e_rl = '0;
        if (rst) begin
            h1 = '0; h2 = '0; m_lvl = '0;
            for (int b = 0; b < N; b++) begin run[b] = 0; rep[b] = 0; end
        end else begin
            for (int b = 0; b < N; b++) begin
                s = h2[b];
`ifdef BTN_AUTOREPEAT_EN
                if (m_lvl[b] && run[b] == 0 && s) begin
                    rep[b]++;
                    if (rep[b] == RD || (rep[b] > RD && (rep[b] - RD) % RP == 0))
                        e_pr[b] = 1'b1;
                end
`endif
                if (s != m_lvl[b]) run[b]++;
                else               run[b] = 0;
                if (run[b] == DB) begin
                    m_lvl[b] = ~m_lvl[b];
                    run[b]   = 0;
                    if (m_lvl[b]) begin e_pr[b] = 1'b1; rep[b] = 0; end
                    else          e_rl[b] = 1'b1;
                end
            end
            h2 = h1;
            h1 = bus.btn_raw;
        end
        e_lvl = m_lvl;
        e_any = |e_pr;
        e_id  = 2'd0;
        for (int b = N - 1; b >= 0; b--) if (e_pr[b]) e_id = 2'(b);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("model", {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press, bus.press_id},
                       {e_lvl, e_pr, e_rl, e_any, e_id});
    endtask

    vec_t vecs[11];
    int   pc, rc, k, hit;
    int   got_q[$];
    int   exp_q[$];

    initial begin
        vecs[0]  = '{3'b000, 8, 3'b000, 0, 1};
        vecs[1]  = '{3'b010, 3, 3'b000, 0, 0};
        vecs[2]  = '{3'b000, 1, 3'b000, 0, 0};
        vecs[3]  = '{3'b010, 8, 3'b010, 1, 0};
        vecs[4]  = '{3'b000, 8, 3'b000, 0, 1};
        vecs[5]  = '{3'b110, 8, 3'b110, 2, 0};
        vecs[6]  = '{3'b000, 8, 3'b000, 0, 2};
        vecs[7]  = '{3'b111, 8, 3'b111, 3, 0};
        vecs[8]  = '{3'b011, 2, 3'b111, 0, 0};
        vecs[9]  = '{3'b111, 3, 3'b111, 0, 0};
        vecs[10] = '{3'b000, 8, 3'b000, 0, 3};

        rst = 1'b1;
        bus.btn_raw = '0;
        @(negedge clk);
        tick();
        tick();
        check("reset_zero", {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press, bus.press_id}, '0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Press latency: raw rises before edge 1, press lands after edge DB+2.
        bus.btn_raw = 3'b001;
        hit = 0; pc = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.btn_press[0]) begin hit = i; pc++; end
        end
        check("press_edge", 32'(hit), 32'(DB + 2));
        check("press_once", 32'(pc), 32'd1);
        check("level_held", {31'd0, bus.btn_level[0]}, 32'd1);

        foreach (vecs[v]) begin
            bus.btn_raw = vecs[v].raw;
            pc = 0; rc = 0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                tick();
                pc += $countones(bus.btn_press);
                rc += $countones(bus.btn_release);
            end
            check($sformatf("vec%0d_level", v), 32'(bus.btn_level), 32'(vecs[v].lvl_end));
            check($sformatf("vec%0d_press", v), 32'(pc), 32'(vecs[v].presses));
            check($sformatf("vec%0d_release", v), 32'(rc), 32'(vecs[v].releases));
        end

        // Reset while held: outputs clear at once, then a fresh qualification.
        bus.btn_raw = 3'b100;
        k = 0;
        while (!bus.btn_level[2] && k < 20) begin tick(); k++; end
        check("held_level_timeout", {31'd0, bus.btn_level[2]}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("rst_midop_zero", {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press, bus.press_id}, '0);
        rst = 1'b0;
        hit = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.btn_press[2] && hit == 0) hit = i;
        end
        check("rst_requal_edge", 32'(hit), 32'(DB + 2));

        // Long hold: one press, or a repeating train when auto-repeat is built in.
        bus.btn_raw = 3'b000;
        for (int i = 0; i < 8; i++) tick();
        bus.btn_raw = 3'b001;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.btn_press[0]) got_q.push_back(i);
        end
`ifdef BTN_AUTOREPEAT_EN
        exp_q = '{6, 16, 19, 22, 25, 28};
`else
        exp_q = '{6};
`endif
        check("hold_press_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("hold_press%0d_edge", i), 32'(got_q[i]), 32'(exp_q[i]));

        // Random bouncing inputs with occasional resets, checked against the model.
        bus.btn_raw = 3'b000;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) bus.btn_raw[b] = ~bus.btn_raw[b];
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
